// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit.
//   Multiplies take one MUL cycle. Divides run 32 restoring radix-2 iterations
//   on operand magnitudes, then sign-correct the result on the way into DONE.
//   A zero divisor and signed overflow skip the iterations and finish at once.
// Ports:
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   START, FUNCT3     operation request (sampled in IDLE/DONE) and RV32M funct3
//   OPERAND1/2        rs1 / rs2, latched on the accepting edge
//   FLUSH             abort any in-flight operation, RESULT untouched
//   BUSY              high while in MUL or DIV (pipeline stall)
//   RESULT_VALID      one-cycle pulse in DONE
//   RESULT            registered result, changes only on entry to DONE
module muldiv_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] OPERAND1,
  input  logic [31:0] OPERAND2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        RESULT_VALID,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  // funct3[2] only steers the accept decision, so just the low bits are kept:
  // mul: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; div: bit0 unsigned, bit1 rem.
  logic [1:0]  f3_q, f3_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // Multiplier: sign-extend to 64 bits; the low 64 bits of the product are
  // correct for any signedness mix.
  logic        mul_s1, mul_s2;
  logic [63:0] mul_a, mul_b, prod;
  assign mul_s1 = ~(f3_q[1] & f3_q[0]);
  assign mul_s2 = (f3_q == 2'b01);
  assign mul_a  = {{32{mul_s1 & op1_q[31]}}, op1_q};
  assign mul_b  = {{32{mul_s2 & op2_q[31]}}, op2_q};
  assign prod   = mul_a * mul_b;

  // One restoring iteration: 33-bit shifted remainder vs zero-extended divisor.
  logic [32:0] rem_sh, rem_df;
  logic        rem_ge;
  logic [31:0] rem_n, quot_n, q_fix, r_fix;
  assign rem_sh = {rem_q, quot_q[31]};
  assign rem_df = rem_sh - {1'b0, dvsr_q};
  assign rem_ge = ~rem_df[32];
  assign rem_n  = rem_ge ? rem_df[31:0] : rem_sh[31:0];
  assign quot_n = {quot_q[30:0], rem_ge};
  assign q_fix  = (!f3_q[0] && (op1_q[31] ^ op2_q[31])) ? (~quot_n + 32'd1) : quot_n;
  assign r_fix  = (!f3_q[0] && op1_q[31]) ? (~rem_n + 32'd1) : rem_n;

  // Magnitudes of the incoming operands for signed divides.
  logic        in_sgn;
  logic [31:0] abs1, abs2;
  assign in_sgn = ~FUNCT3[0];
  assign abs1   = (in_sgn && OPERAND1[31]) ? (~OPERAND1 + 32'd1) : OPERAND1;
  assign abs2   = (in_sgn && OPERAND2[31]) ? (~OPERAND2 + 32'd1) : OPERAND2;

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (START) begin
          f3_d  = FUNCT3[1:0];
          op1_d = OPERAND1;
          op2_d = OPERAND2;
          if (!FUNCT3[2]) begin
            state_d = S_MUL;
          end else if (OPERAND2 == 32'd0) begin
            state_d  = S_DONE;
            result_d = FUNCT3[1] ? OPERAND1 : 32'hFFFF_FFFF;
          end else if (!FUNCT3[0] && OPERAND1 == 32'h8000_0000 &&
                       OPERAND2 == 32'hFFFF_FFFF) begin
            state_d  = S_DONE;
            result_d = FUNCT3[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_d = S_DIV;
            rem_d   = 32'd0;
            quot_d  = abs1;
            dvsr_d  = abs2;
            cnt_d   = 5'd31;
          end
        end
      end
      S_MUL: begin
        state_d  = S_DONE;
        result_d = (f3_q == 2'b00) ? prod[31:0] : prod[63:32];
      end
      S_DIV: begin
        rem_d  = rem_n;
        quot_d = quot_n;
        if (cnt_q == 5'd0) begin
          state_d  = S_DONE;
          result_d = f3_q[1] ? r_fix : q_fix;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over START and any completion: no DONE, result held.
    if (FLUSH) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      f3_q     <= 2'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      rem_q    <= 32'd0;
      quot_q   <= 32'd0;
      dvsr_q   <= 32'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign BUSY         = (state_q == S_MUL) || (state_q == S_DIV);
  assign RESULT_VALID = (state_q == S_DONE);
  assign RESULT       = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer. Inputs change #1 after a rising edge,
// outputs are read at that same point, i.e. well away from the next edge.
module tb_muldiv_sequencer;
  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1, OPERAND2;
  logic        BUSY, RESULT_VALID;
  logic [31:0] RESULT;

  int vec_cnt = 0;
  int err_cnt = 0;

  muldiv_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .FLUSH(FLUSH),
    .BUSY(BUSY), .RESULT_VALID(RESULT_VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one op and follow it until RESULT_VALID (cycle numbers relative to
  // the accepting edge = cycle 0). lat = 0 means no result within 40 cycles.
  // Operand inputs are scrambled after acceptance to prove they were latched.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output int busy_cnt, output logic [31:0] res);
    START = 1'b1; FUNCT3 = f3; OPERAND1 = a; OPERAND2 = b;
    step();
    START = 1'b0; FUNCT3 = $urandom_range(7, 0);
    OPERAND1 = $urandom; OPERAND2 = $urandom;
    lat = 0; busy_cnt = 0; res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      if (BUSY) busy_cnt++;
      if (RESULT_VALID) begin
        lat = c;
        res = RESULT;
        break;
      end
      step();
    end
  endtask

  // Shared vector runner used by the functional tests; each test owns its table.
  task automatic test_vec(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_res);
    int lat, bc;
    logic [31:0] res;
    run_op(f3, a, b, lat, bc, res);
    vec_cnt++;
    if (lat !== exp_lat) begin
      err_cnt++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    vec_cnt++;
    if (bc !== exp_lat - 1) begin
      err_cnt++; $display("FAIL %s busy cycles: got %0d want %0d", name, bc, exp_lat - 1);
    end
    vec_cnt++;
    if (res !== exp_res) begin
      err_cnt++; $display("FAIL %s result: got %h want %h", name, res, exp_res);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1; FLUSH = 1'b1; FUNCT3 = 3'b000;
    OPERAND1 = 32'd3; OPERAND2 = 32'd4;
    step(); step();
    vec_cnt++;
    if (BUSY !== 1'b0) begin err_cnt++; $display("FAIL reset busy: got %b want 0", BUSY); end
    vec_cnt++;
    if (RESULT_VALID !== 1'b0) begin err_cnt++; $display("FAIL reset valid: got %b want 0", RESULT_VALID); end
    vec_cnt++;
    if (RESULT !== 32'd0) begin err_cnt++; $display("FAIL reset result: got %h want 0", RESULT); end
    RESET = 1'b0; START = 1'b0; FLUSH = 1'b0;
    step();
  endtask

  task automatic test_mul();
    test_vec("mulh_m1_m1",  3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000);
    test_vec("mulhu_m1_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    test_vec("mulhsu_m1",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
    test_vec("mulhsu_2",    3'b010, 32'h0000_0002, 32'h8000_0000, 2, 32'h0000_0001);
    test_vec("mul_low",     3'b000, 32'h1234_5678, 32'h0000_0010, 2, 32'h2345_6780);
  endtask

  task automatic test_div();
    test_vec("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    test_vec("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    test_vec("divu_100_7", 3'b101, 32'd100, 32'd7, 33, 32'd14);
    test_vec("remu_100_7", 3'b111, 32'd100, 32'd7, 33, 32'd2);
    test_vec("div_7_m2",  3'b100, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    test_vec("rem_7_m2",  3'b110, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
  endtask

  task automatic test_div_zero();
    test_vec("divu_by0", 3'b101, 32'd100, 32'd0, 1, 32'hFFFF_FFFF);
    test_vec("remu_by0", 3'b111, 32'd100, 32'd0, 1, 32'd100);
    test_vec("rem_m5_by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB);
  endtask

  task automatic test_overflow();
    test_vec("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    test_vec("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
  endtask

  task automatic test_flush();
    logic saw_valid;
    test_vec("pre_flush_mul", 3'b000, 32'd5, 32'd6, 2, 32'd30);
    step();  // back to IDLE
    // FLUSH together with START in IDLE: nothing accepted
    START = 1'b1; FLUSH = 1'b1; FUNCT3 = 3'b000; OPERAND1 = 32'd2; OPERAND2 = 32'd2;
    step();
    START = 1'b0; FLUSH = 1'b0;
    vec_cnt++;
    if (BUSY !== 1'b0) begin err_cnt++; $display("FAIL flush_over_start busy: got %b want 0", BUSY); end
    // DIVU 0xFFFFFFFF/3, FLUSH driven during cycle 10
    START = 1'b1; FUNCT3 = 3'b101; OPERAND1 = 32'hFFFF_FFFF; OPERAND2 = 32'd3;
    step();                       // cycle 1
    START = 1'b0;
    saw_valid = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      if (c == 5) START = 1'b1;   // ignored while dividing
      if (c == 6) START = 1'b0;
      step();
      if (RESULT_VALID) saw_valid = 1'b1;
    end
    FLUSH = 1'b1;
    step();                       // cycle 11
    FLUSH = 1'b0;
    vec_cnt++;
    if (BUSY !== 1'b0) begin err_cnt++; $display("FAIL flush busy: got %b want 0", BUSY); end
    vec_cnt++;
    if (RESULT !== 32'd30) begin err_cnt++; $display("FAIL flush result held: got %h want %h", RESULT, 32'd30); end
    if (RESULT_VALID) saw_valid = 1'b1;
    vec_cnt++;
    if (saw_valid !== 1'b0) begin err_cnt++; $display("FAIL flush valid pulse: got %b want 0", saw_valid); end
    // new START in cycle 12
    test_vec("post_flush_divu", 3'b101, 32'hFFFF_FFFF, 32'd3, 33, 32'h5555_5555);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] res;
    step();
    test_vec("b2b_mul", 3'b000, 32'd5, 32'd6, 2, 32'd30);
    // now in DONE of the MUL: start DIVU 30/4 directly
    START = 1'b1; FUNCT3 = 3'b101; OPERAND1 = 32'd30; OPERAND2 = 32'd4;
    step();
    START = 1'b0;
    vec_cnt++;
    if (BUSY !== 1'b1 || RESULT_VALID !== 1'b0) begin
      err_cnt++; $display("FAIL b2b no bubble: busy %b valid %b want 1 0", BUSY, RESULT_VALID);
    end
    lat = 0; res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 40; c++) begin
      if (RESULT_VALID) begin lat = c; res = RESULT; break; end
      step();
    end
    vec_cnt++;
    if (lat !== 33) begin err_cnt++; $display("FAIL b2b divu latency: got %0d want 33", lat); end
    vec_cnt++;
    if (res !== 32'd7) begin err_cnt++; $display("FAIL b2b divu result: got %h want 7", res); end
    // RESET in cycle 5 of a DIVU
    START = 1'b1; FUNCT3 = 3'b101; OPERAND1 = 32'd30; OPERAND2 = 32'd4;
    step();
    START = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    RESET = 1'b1;
    step();
    vec_cnt++;
    if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0 || RESULT !== 32'd0) begin
      err_cnt++; $display("FAIL reset mid-div: busy %b valid %b result %h want 0 0 0",
                          BUSY, RESULT_VALID, RESULT);
    end
    RESET = 1'b0;
    step();
    run_op(3'b000, 32'd5, 32'd6, lat, bc, res);
    vec_cnt++;
    if (lat !== 2 || res !== 32'd30) begin
      err_cnt++; $display("FAIL post-reset mul: lat %0d result %h want 2 %h", lat, res, 32'd30);
    end
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; FUNCT3 = 3'b000;
    OPERAND1 = 32'd0; OPERAND2 = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK and RESET.
REQ-002 Port CLK  input  1  rising-edge clock for all state.
REQ-003 Port RESET  input  1  synchronous, active-high reset.
REQ-004 Port START  input  1  request to begin an RV32M operation; sampled only in IDLE or DONE.
REQ-005 Port FUNCT3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port OPERAND1  input  32  rs1 value (multiplicand/dividend).
REQ-007 Port OPERAND2  input  32  rs2 value (multiplier/divisor).
REQ-008 Port FLUSH  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 Port BUSY  output  1  stall request to the pipeline; high in MUL and DIV states.
REQ-010 Port RESULT_VALID  output  1  one-cycle pulse, high only in DONE.
REQ-011 Port RESULT  output  32  registered result, held stable until the next accepted START.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV, DONE; BUSY = (MUL or DIV); RESULT_VALID = DONE.
REQ-013 START in IDLE or DONE SHALL latch FUNCT3 and both operands on that edge (cycle 0); START in MUL/DIV SHALL be ignored.
REQ-014 FUNCT3[2]=0 SHALL go to MUL for exactly one cycle, then DONE; RESULT_VALID in cycle 2.
REQ-015 MUL SHALL form a 64-bit product: MUL low 32 bits; MULH signed x signed high 32; MULHSU signed rs1 x unsigned rs2 high 32; MULHU unsigned x unsigned high 32.
REQ-016 FUNCT3[2]=1 with OPERAND2=0 SHALL go directly to DONE (RESULT_VALID in cycle 1): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> OPERAND1.
REQ-017 DIV/REM with OPERAND1=0x80000000 and OPERAND2=0xFFFFFFFF SHALL go directly to DONE: DIV -> 0x80000000; REM -> 0.
REQ-018 Other divides SHALL run restoring radix-2 division on magnitudes (signed ops take absolute values; unsigned ops use raw operands) for exactly 32 DIV cycles, with a 5-bit counter from 31 down to 0; DONE in cycle 33.
REQ-019 Each DIV iteration: shift {rem,quot} left 1; if rem >= divisor, subtract and set quot[0]=1; the rem compare/subtract SHALL be 33 bits wide.
REQ-020 Sign correction on entry to DONE: DIV quotient negated if operand signs differ; REM remainder takes the dividend's sign; DIVU/REMU uncorrected.
REQ-021 DONE SHALL last one cycle, then go to IDLE, or to MUL/DIV/DONE if START is high in DONE (back-to-back, no bubble).
REQ-022 FLUSH SHALL force IDLE on the next edge from any state, takes priority over START, and SHALL leave RESULT unchanged with no RESULT_VALID pulse.
REQ-023 RESULT SHALL update only on the edge entering DONE.

Reset
REQ-024 RESET SHALL take priority over FLUSH and START and force state IDLE, BUSY=0, RESULT_VALID=0, RESULT=0x00000000, counter=0, operand registers=0.
REQ-025 RESET asserted mid-MUL or mid-DIV SHALL abort the operation with no RESULT_VALID pulse; the first START after RESET deasserts SHALL be accepted normally.

Verification
REQ-026 MULH, OPERAND1=0xFFFFFFFF, OPERAND2=0xFFFFFFFF -> BUSY high in cycle 1; RESULT_VALID in cycle 2; RESULT=0x00000000 (MULHU same operands -> 0xFFFFFFFE).
REQ-027 DIV, -7 (0xFFFFFFF9) / 2 -> BUSY high cycles 1-32; RESULT_VALID in cycle 33; RESULT=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-028 DIVU 100/0 -> RESULT_VALID in cycle 1, RESULT=0xFFFFFFFF, BUSY never high; REMU 100/0 -> RESULT=100.
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> RESULT_VALID in cycle 1, RESULT=0x80000000; REM -> RESULT=0.
REQ-030 DIVU 0xFFFFFFFF/3 with FLUSH in cycle 10 -> IDLE in cycle 11, no RESULT_VALID, prior RESULT held; a new START in cycle 12 completes correctly with RESULT=0x55555555.
REQ-031 START issued in the DONE cycle of a MUL (5x6=30) with a DIVU 30/4 -> RESULT_VALID back-to-back results 30 then 7, no idle cycle between acceptance and DIV; RESET in cycle 5 of the DIVU -> all outputs 0 from the next edge.
